// File: rtl/turn_sequencer.sv
// Turn controller for 2048: arbitrates direction buttons, sequences the slide and spawn engines,
// and owns the committed board. Seeds the board with two spawns after reset.
module turn_sequencer #(
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned TW      = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   output logic        slide_start,
   output logic [1:0]  slide_dir,
   output logic [63:0] slide_in,
   input  logic        slide_done,
   input  logic [63:0] slide_out,
   input  logic        slide_changed,
   output logic        spawn_req,
   output logic [63:0] spawn_in,
   input  logic        spawn_busy,
   input  logic [63:0] spawn_out,
   output logic [63:0] board,
   output logic        busy,
   output logic        pending,
   output logic        fault
);

   typedef enum logic [2:0] {
      StInitReq,
      StInitWait,
      StIdle,
      StSlideReq,
      StSlideWait,
      StSpawnReq,
      StSpawnWait,
      StFault
   } state_e;

   state_e        state_q, state_d;
   logic [63:0]   board_q, board_d;
   logic [1:0]    dir_q, dir_d;
   logic          pend_q, pend_d;
   logic [1:0]    pend_dir_q, pend_dir_d;
   logic [TW-1:0] wdog_q, wdog_d;
   logic          init_cnt_q, init_cnt_d;
   logic          slide_start_q, slide_start_d;
   logic          spawn_req_q, spawn_req_d;

   logic          press;
   logic [1:0]    win_dir;
   logic          spawn_done;
   logic          timeout_hit;

   assign press   = up | down | left | right;
   assign win_dir = up ? 2'd0 : down ? 2'd1 : left ? 2'd2 : 2'd3;

   // The request strobe is registered, so busy is only meaningful from the cycle after it.
   assign spawn_done  = !spawn_busy && !spawn_req_q;
   assign timeout_hit = (wdog_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      board_d       = board_q;
      dir_d         = dir_q;
      pend_d        = pend_q;
      pend_dir_d    = pend_dir_q;
      wdog_d        = wdog_q;
      init_cnt_d    = init_cnt_q;
      slide_start_d = 1'b0;
      spawn_req_d   = 1'b0;

      if (state_q != StIdle && state_q != StFault && press) begin
         pend_d     = 1'b1;
         pend_dir_d = win_dir;
      end

      case (state_q)
         StInitReq: begin
            spawn_req_d = 1'b1;
            wdog_d      = '0;
            state_d     = StInitWait;
         end
         StInitWait: begin
            if (spawn_done) begin
               board_d    = spawn_out;
               init_cnt_d = 1'b1;
               state_d    = init_cnt_q ? StIdle : StInitReq;
            end else if (timeout_hit) begin
               state_d = StFault;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StIdle: begin
            if (pend_q) begin
               dir_d      = pend_dir_q;
               state_d    = StSlideReq;
               pend_d     = press;
               pend_dir_d = press ? win_dir : pend_dir_q;
            end else if (press) begin
               dir_d   = win_dir;
               state_d = StSlideReq;
            end
         end
         StSlideReq: begin
            slide_start_d = 1'b1;
            wdog_d        = '0;
            state_d       = StSlideWait;
         end
         StSlideWait: begin
            if (slide_done) begin
               if (slide_changed) begin
                  board_d = slide_out;
                  state_d = StSpawnReq;
               end else begin
                  state_d = StIdle;
               end
            end else if (timeout_hit) begin
               state_d = StFault;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StSpawnReq: begin
            spawn_req_d = 1'b1;
            wdog_d      = '0;
            state_d     = StSpawnWait;
         end
         StSpawnWait: begin
            if (spawn_done) begin
               board_d = spawn_out;
               state_d = StIdle;
            end else if (timeout_hit) begin
               state_d = StFault;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StFault;
         end
      endcase

      if (state_d == StFault) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StInitReq;
         board_q       <= '0;
         dir_q         <= '0;
         pend_q        <= 1'b0;
         pend_dir_q    <= '0;
         wdog_q        <= '0;
         init_cnt_q    <= 1'b0;
         slide_start_q <= 1'b0;
         spawn_req_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         dir_q         <= dir_d;
         pend_q        <= pend_d;
         pend_dir_q    <= pend_dir_d;
         wdog_q        <= wdog_d;
         init_cnt_q    <= init_cnt_d;
         slide_start_q <= slide_start_d;
         spawn_req_q   <= spawn_req_d;
      end
   end

   assign slide_start = slide_start_q;
   assign slide_dir   = dir_q;
   assign slide_in    = board_q;
   assign spawn_req   = spawn_req_q;
   assign spawn_in    = board_q;
   assign board       = board_q;
   assign busy        = (state_q != StIdle);
   assign pending     = pend_q;
   assign fault       = (state_q == StFault);

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with behavioural slide and spawn engine responders.
module tb_turn_sequencer;

   localparam int unsigned TO = 1023;

   logic        clk;
   logic        rst;
   logic        up, down, left, right;
   logic        slide_start;
   logic [1:0]  slide_dir;
   logic [63:0] slide_in;
   logic        slide_done;
   logic [63:0] slide_out;
   logic        slide_changed;
   logic        spawn_req;
   logic [63:0] spawn_in;
   logic        spawn_busy;
   logic [63:0] spawn_out;
   logic [63:0] board;
   logic        busy;
   logic        pending;
   logic        fault;

   int checks = 0;
   int errors = 0;

   logic [63:0] spawn_seq [10];
   int          spawn_idx = 0;
   logic [63:0] slide_val;
   logic        slide_chg;
   logic        slide_hang;

   int   slide_cnt = 0;
   int   spawn_cnt = 0;
   int   strobe_err = 0;
   logic slide_prev = 1'b0;
   logic spawn_prev = 1'b0;

   turn_sequencer #(
      .TIMEOUT(TO),
      .TW     (10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .up           (up),
      .down         (down),
      .left         (left),
      .right        (right),
      .slide_start  (slide_start),
      .slide_dir    (slide_dir),
      .slide_in     (slide_in),
      .slide_done   (slide_done),
      .slide_out    (slide_out),
      .slide_changed(slide_changed),
      .spawn_req    (spawn_req),
      .spawn_in     (spawn_in),
      .spawn_busy   (spawn_busy),
      .spawn_out    (spawn_out),
      .board        (board),
      .busy         (busy),
      .pending      (pending),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe counters and single-cycle width monitor.
   always @(negedge clk) begin
      if (slide_start) slide_cnt <= slide_cnt + 1;
      if (spawn_req) spawn_cnt <= spawn_cnt + 1;
      if ((slide_start && slide_prev) || (spawn_req && spawn_prev)) strobe_err <= strobe_err + 1;
      slide_prev <= slide_start;
      spawn_prev <= spawn_req;
   end

   // Spawn engine: busy from the cycle after the request for 3 cycles, then result.
   initial begin
      spawn_busy = 1'b0;
      spawn_out  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (spawn_req === 1'b1) begin
            @(posedge clk);
            #1;
            spawn_busy = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            spawn_busy = 1'b0;
            spawn_out  = (spawn_idx < 10) ? spawn_seq[spawn_idx] : 64'h0;
            spawn_idx++;
         end
      end
   end

   // Slide engine: done pulse 4 cycles after the start strobe unless hung.
   initial begin
      slide_done    = 1'b0;
      slide_out     = '0;
      slide_changed = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (slide_start === 1'b1 && !slide_hang) begin
            repeat (4) @(posedge clk);
            #1;
            slide_done    = 1'b1;
            slide_out     = slide_val;
            slide_changed = slide_chg;
            @(posedge clk);
            #1;
            slide_done = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check(tag, {63'd0, busy}, 64'd0);
   endtask

   int sp0;
   int sl0;
   int n;

   initial begin
      spawn_seq[0] = 64'h1;
      spawn_seq[1] = 64'h101;
      spawn_seq[2] = 64'h1001;
      spawn_seq[3] = 64'h2011;
      spawn_seq[4] = 64'h3012;
      spawn_seq[5] = 64'h10;
      spawn_seq[6] = 64'h110;
      spawn_seq[7] = 64'hDEAD;
      spawn_seq[8] = 64'h4;
      spawn_seq[9] = 64'h44;
      rst = 1'b1;
      up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
      slide_val = '0; slide_chg = 1'b0; slide_hang = 1'b0;

      // Reset values and seeding
      tick();
      check("rst_board", board, 64'h0);
      check("rst_spawn_req", {63'd0, spawn_req}, 64'd0);
      check("rst_slide_start", {63'd0, slide_start}, 64'd0);
      check("rst_dir", {62'd0, slide_dir}, 64'd0);
      check("rst_pending", {63'd0, pending}, 64'd0);
      check("rst_fault", {63'd0, fault}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd1);
      tick();
      rst = 1'b0;
      sp0 = spawn_cnt;
      wait_idle("init_idle");
      check("init_spawns", 64'(spawn_cnt - sp0), 64'd2);
      check("init_board", board, 64'h101);

      // Normal move
      slide_val = 64'h1; slide_chg = 1'b1;
      sp0 = spawn_cnt;
      left = 1'b1;
      tick();
      left = 1'b0;
      check("move_start_early", {63'd0, slide_start}, 64'd0);
      tick();
      check("move_start", {63'd0, slide_start}, 64'd1);
      check("move_dir", {62'd0, slide_dir}, 64'd2);
      check("move_slide_in", slide_in, 64'h101);
      wait_idle("move_idle");
      check("move_spawns", 64'(spawn_cnt - sp0), 64'd1);
      check("move_board", board, 64'h1001);

      // No-change move
      slide_val = 64'hFFFF; slide_chg = 1'b0;
      sp0 = spawn_cnt;
      up = 1'b1;
      tick();
      up = 1'b0;
      tick();
      check("nochg_dir", {62'd0, slide_dir}, 64'd0);
      n = 0;
      while (slide_done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("nochg_done_seen", {63'd0, slide_done}, 64'd1);
      tick();
      check("nochg_idle", {63'd0, busy}, 64'd0);
      check("nochg_board", board, 64'h1001);
      repeat (3) tick();
      check("nochg_spawns", 64'(spawn_cnt - sp0), 64'd0);

      // Simultaneous press, then queued presses while busy
      slide_val = 64'h2001; slide_chg = 1'b1;
      sl0 = slide_cnt;
      up = 1'b1; right = 1'b1;
      tick();
      up = 1'b0; right = 1'b0;
      tick();
      check("simul_start", {63'd0, slide_start}, 64'd1);
      check("simul_dir", {62'd0, slide_dir}, 64'd0);
      down = 1'b1;
      tick();
      down = 1'b0; right = 1'b1;
      tick();
      right = 1'b0;
      check("queue_pending", {63'd0, pending}, 64'd1);
      n = 0;
      while (slide_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("queue_start_seen", {63'd0, slide_start}, 64'd1);
      slide_val = 64'h2012;
      check("queue_dir", {62'd0, slide_dir}, 64'd3);
      check("queue_pending_clr", {63'd0, pending}, 64'd0);
      wait_idle("queue_idle");
      repeat (3) tick();
      check("queue_moves", 64'(slide_cnt - sl0), 64'd2);
      check("queue_board", board, 64'h3012);

      // Watchdog timeout
      slide_hang = 1'b1;
      left = 1'b1;
      tick();
      left = 1'b0;
      tick();
      check("to_start", {63'd0, slide_start}, 64'd1);
      repeat (TO - 1) tick();
      check("to_fault_early", {63'd0, fault}, 64'd0);
      tick();
      check("to_fault", {63'd0, fault}, 64'd1);
      check("to_board", board, 64'h3012);
      check("to_busy", {63'd0, busy}, 64'd1);
      slide_hang = 1'b0;
      sl0 = slide_cnt;
      up = 1'b1;
      tick();
      up = 1'b0;
      repeat (3) tick();
      check("to_pending", {63'd0, pending}, 64'd0);
      check("to_no_move", 64'(slide_cnt - sl0), 64'd0);
      check("to_sticky", {63'd0, fault}, 64'd1);
      rst = 1'b1;
      tick();
      check("to_rst_fault", {63'd0, fault}, 64'd0);
      tick();
      rst = 1'b0;
      sp0 = spawn_cnt;
      wait_idle("to_reinit_idle");
      check("to_reinit_spawns", 64'(spawn_cnt - sp0), 64'd2);
      check("to_reinit_board", board, 64'h110);

      // Reset during SPAWN_WAIT, late engine response
      slide_val = 64'h111; slide_chg = 1'b1;
      down = 1'b1;
      tick();
      down = 1'b0;
      n = 0;
      while (spawn_busy !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("mid_spawn_busy", {63'd0, spawn_busy}, 64'd1);
      rst = 1'b1;
      tick();
      check("mid_board", board, 64'h0);
      check("mid_busy", {63'd0, busy}, 64'd1);
      check("mid_spawn_req", {63'd0, spawn_req}, 64'd0);
      repeat (5) tick();
      check("mid_late_fall", {63'd0, spawn_busy}, 64'd0);
      check("mid_board_late", board, 64'h0);
      rst = 1'b0;
      wait_idle("mid_reinit_idle");
      check("mid_reinit_board", board, 64'h44);

      check("strobe_width", 64'(strobe_err), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
